// File: rtl/qspi_mem_responder_if.sv
// QSPI pin bundle between an initiator (master) and qspi_mem_responder (slave).
interface qspi_mem_responder_if;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic [3:0] spi_io_in;
   logic [3:0] spi_io_out;
   logic [3:0] spi_io_oe;

   modport master (
      output spi_sclk, spi_cs_n, spi_io_in,
      input  spi_io_out, spi_io_oe
   );

   modport slave (
      input  spi_sclk, spi_cs_n, spi_io_in,
      output spi_io_out, spi_io_oe
   );
endinterface

// File: rtl/qspi_mem_responder.sv
// Quad-SPI memory target: 0xEB quad read from a DEPTH-byte array with a backdoor load port;
// 0x38 quad write exists only when QSPI_RESP_WRITE_EN is defined. SPI pins are oversampled on clk.
module qspi_mem_responder #(
   parameter int DEPTH = 256,
   parameter int DUMMY = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   qspi_mem_responder_if.slave  spi,
   input  logic                 ld_we,
   input  logic [7:0]           ld_addr,
   input  logic [7:0]           ld_data,
   output logic                 busy
);
   localparam int         AW         = $clog2(DEPTH);
   localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 1);
   localparam logic [7:0] CMD_READ   = 8'hEB;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
   } state_t;

   localparam state_t S_AFTER_ADDR = (DUMMY == 0) ? S_READ : S_DUMMY;

   state_t        state, state_n;
   logic [7:0]    mem [DEPTH];

   logic          sclk_s1, sclk_s2, sclk_d;
   logic          cs_s1, cs_s2, cs_d;
   logic [3:0]    io_s1, io_s2;
   logic [1:0]    settle;
   logic          armed;

   logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [3:0]    cnt, nib_hold;
   logic          phase;
   logic [AW-1:0] ptr;
   logic [7:0]    cmd_byte, rd_byte;
   logic          cmd_ok, addr_to_write;
   logic [3:0]    io_out_r, io_oe_r;

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   assign cs_rise   = cs_s2 & ~cs_d;
   assign cs_fall   = ~cs_s2 & cs_d;
   assign busy      = ~cs_s2;
   assign cmd_byte  = {nib_hold, io_s2};
   assign rd_byte   = mem[ptr];

   assign spi.spi_io_out = io_out_r;
   assign spi.spi_io_oe  = io_oe_r;

   // Arming waits until the synchroniser holds real pin samples, so a cs_n already low
   // at reset release is not mistaken for a fresh select.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_d    <= 1'b1;
         io_s1   <= 4'h0;
         io_s2   <= 4'h0;
         settle  <= 2'd0;
         armed   <= 1'b0;
      end else begin
         sclk_s1 <= spi.spi_sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         cs_s1   <= spi.spi_cs_n;
         cs_s2   <= cs_s1;
         cs_d    <= cs_s2;
         io_s1   <= spi.spi_io_in;
         io_s2   <= io_s1;
         if (settle != 2'd2) settle <= settle + 2'd1;
         if (settle == 2'd2 && cs_s2) armed <= 1'b1;
      end
   end

`ifdef QSPI_RESP_WRITE_EN
   logic is_write;
   logic spi_we;

   assign cmd_ok        = (cmd_byte == CMD_READ) || (cmd_byte == 8'h38);
   assign addr_to_write = is_write;
   assign spi_we        = (state == S_WRITE) && sclk_rise && phase && !cs_rise;

   always_ff @(posedge clk) begin
      if (reset) begin
         is_write <= 1'b0;
      end else if (state == S_CMD && sclk_rise && cnt == 4'd1) begin
         is_write <= (cmd_byte == 8'h38);
      end
   end
`else
   assign cmd_ok        = (cmd_byte == CMD_READ);
   assign addr_to_write = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (cs_rise) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (cs_fall && armed) state_n = S_CMD;
            S_CMD:   if (sclk_rise && cnt == 4'd1) state_n = cmd_ok ? S_ADDR : S_IGNORE;
            S_ADDR:  if (sclk_rise && cnt == 4'd5) state_n = addr_to_write ? S_WRITE : S_AFTER_ADDR;
            S_DUMMY: if (sclk_rise && cnt == DUMMY_LAST) state_n = S_READ;
            default: state_n = state;
         endcase
      end
   end

   // phase selects the nibble within the current byte: 0 = high, 1 = low
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= 4'd0;
         nib_hold <= 4'h0;
         phase    <= 1'b0;
         ptr      <= '0;
         io_out_r <= 4'h0;
         io_oe_r  <= 4'h0;
      end else begin
         if (sclk_rise) nib_hold <= io_s2;
         if (state_n != state) begin
            cnt   <= 4'd0;
            phase <= 1'b0;
         end else if (sclk_rise) begin
            cnt <= cnt + 4'd1;
         end
         if (cs_rise) begin
            io_out_r <= 4'h0;
            io_oe_r  <= 4'h0;
         end else begin
            case (state)
               S_ADDR: if (sclk_rise) ptr <= AW'({ptr, io_s2});
               S_READ: if (sclk_fall) begin
                  io_oe_r  <= 4'hF;
                  io_out_r <= phase ? rd_byte[3:0] : rd_byte[7:4];
                  phase    <= ~phase;
                  if (phase) ptr <= ptr + AW'(1);
               end
`ifdef QSPI_RESP_WRITE_EN
               S_WRITE: if (sclk_rise) begin
                  phase <= ~phase;
                  if (phase) ptr <= ptr + AW'(1);
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // SPI commit is written last so it wins over a backdoor write to the same byte.
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr[AW-1:0]] <= ld_data;
`ifdef QSPI_RESP_WRITE_EN
      if (spi_we) mem[ptr] <= {nib_hold, io_s2};
`endif
   end
endmodule
